isqrt_pipe_responder: RTL and testbench
=======================================

ISQRT_PIPE_RESPONDER -- requirements
Module: isqrt_pipe_responder

Interface
REQ-001 SHALL have parameter BITS_PER_CYCLE, default 1, root bits resolved per pipeline register stage; legal values 1, 2, 4, 8, 16.
REQ-002 SHALL have derived localparam N = 16 / BITS_PER_CYCLE, pipeline latency in cycles.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port x_vld  input  1  argument valid, one argument per asserted cycle.
REQ-006 SHALL have port x  input  32  unsigned radicand.
REQ-007 SHALL have port y_vld  output  1  result valid, one-cycle pulse per accepted argument.
REQ-008 SHALL have port y  output  16  unsigned root.
REQ-009 SHALL have port busy  output  1  high while any argument is in flight.

Function
REQ-010 SHALL compute y = floor(sqrt(x)) by restoring, non-restoring or digit-recurrence square root, MSB first, BITS_PER_CYCLE root bits per stage.
REQ-011 SHALL accept an argument on every cycle with x_vld=1: no backpressure, throughput one per cycle.
REQ-012 SHALL assert y_vld exactly N cycles after the accepting edge, with y matching that argument.
REQ-013 SHALL return results strictly in acceptance order, with no reordering, merging or dropping.
REQ-014 SHALL carry a per-stage valid bit; a stage with valid=0 SHALL NOT produce y_vld, so gaps in x_vld reappear as identical gaps on y_vld.
REQ-015 SHALL ignore x while x_vld=0; y is don't-care while y_vld=0.
REQ-016 SHALL give each stage registers for valid, remaining radicand bits, partial root (16 bits) and partial remainder (18 bits), with no overflow for any 32-bit x.
REQ-017 SHALL drive busy as the OR of all stage valid bits, including the stage driving y_vld.
REQ-018 SHALL give x=0 -> 0 and x=0xFFFFFFFF -> 0xFFFF, both without wrap.
REQ-019 SHALL contain no combinational path from x or x_vld to y or y_vld.

Reset
REQ-020 SHALL clear all stage valid bits asynchronously on rst_n=0, so y_vld=0 and busy=0 immediately.
REQ-021 SHALL leave datapath registers unreset; y holds an undefined value after reset.
REQ-022 SHALL discard in-flight arguments on reset mid-operation; none produces y_vld after release.
REQ-023 SHALL accept x_vld on the first rising edge with rst_n=1.

Configuration
REQ-024 SHALL, with macro ISQRT_RESP_ROUND_EN defined, output round-to-nearest: r+1 when final remainder (x - r*r) > r, else r.
REQ-025 SHALL saturate at 0xFFFF when rounding up from r=0xFFFF.
REQ-026 SHALL, when ISQRT_RESP_ROUND_EN is defined, add no latency, so y_vld timing is identical with and without the macro.
REQ-027 SHALL, with ISQRT_RESP_ROUND_EN undefined, output floor per REQ-010, with no rounding logic present.

Verification
REQ-028 SHALL cover: BITS_PER_CYCLE=1, single x=16 -> y_vld high 16 cycles later with y=4; busy high during those cycles, low afterwards.
REQ-029 SHALL cover: back-to-back x=100,144,169,0 on 4 consecutive cycles -> y=10,12,13,0 on 4 consecutive cycles starting at cycle N.
REQ-030 SHALL cover: x=2,15,0xFFFFFFFF with one idle cycle between each -> y=1,3,0xFFFF with identical idle gaps.
REQ-031 SHALL cover: rst_n pulled low while 5 arguments are in flight -> y_vld and busy low at once, no y_vld after release, next x=81 -> y=9.
REQ-032 SHALL cover: ISQRT_RESP_ROUND_EN defined, x=12,13,0xFFFFFFFF -> y=3,4,0xFFFF; undefined -> y=3,3,0xFFFF.
REQ-033 SHALL cover: random x each cycle with random x_vld, for all BITS_PER_CYCLE values -> every result matches the reference floor(sqrt) model in order.

Source files
------------

// File: rtl/isqrt_pipe_responder.sv
// isqrt_pipe_responder
// Fully pipelined integer square root, y = floor(sqrt(x)) for a 32-bit x.
// Stage 0 registers the incoming argument. Each of the N following stages
// then resolves BITS_PER_CYCLE root bits, MSB first, using restoring
// digit recurrence. With N = 16 / BITS_PER_CYCLE, a result leaves the pipe
// exactly N cycles after its accepting edge.
// Only the valid chain is reset. The datapath registers hold don't-care
// values whenever their valid bit is low.
// Optional feature: define ISQRT_RESP_ROUND_EN to get round-to-nearest
// output. It is computed from the last stage's registers and adds no latency.

module isqrt_pipe_responder #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy
);

  localparam int N = 16 / BITS_PER_CYCLE;

  // Per-stage registers; index 0 is the input register, index N feeds y
  logic [N:0]  valid_q;
  logic [31:0] rad_q  [0:N];
  logic [15:0] root_q [0:N];
  logic [17:0] rem_q  [0:N];

  // Next-state values for compute stages 1..N
  logic [31:0] rad_d  [1:N];
  logic [15:0] root_d [1:N];
  logic [17:0] rem_d  [1:N];

  // Scratch values for the recurrence. acc is wide enough for 4*rem+3
  logic [31:0] radT;
  logic [15:0] rootT;
  logic [17:0] remT;
  logic [19:0] acc;
  logic [19:0] trial;

  // Digit recurrence: each stage consumes BITS_PER_CYCLE pairs of radicand bits
  always_comb begin
    radT  = '0;
    rootT = '0;
    remT  = '0;
    acc   = '0;
    trial = '0;
    for (int s = 1; s <= N; s++) begin
      radT  = rad_q[s-1];
      rootT = root_q[s-1];
      remT  = rem_q[s-1];
      for (int b = 0; b < BITS_PER_CYCLE; b++) begin
        acc   = {remT, radT[31:30]};
        trial = {2'b00, rootT, 2'b01};
        radT  = {radT[29:0], 2'b00};
        if (acc >= trial) begin
          acc   = acc - trial;
          rootT = {rootT[14:0], 1'b1};
        end else begin
          rootT = {rootT[14:0], 1'b0};
        end
        remT = acc[17:0];
      end
      rad_d[s]  = radT;
      root_d[s] = rootT;
      rem_d[s]  = remT;
    end
  end

  // Valid chain: reset clears every in-flight argument at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= {valid_q[N-1:0], x_vld};
    end
  end

  // Datapath registers (unreset), loaded only when their source stage is valid
  always_ff @(posedge clk) begin
    if (x_vld) begin
      rad_q[0]  <= x;
      root_q[0] <= '0;
      rem_q[0]  <= '0;
    end
    for (int s = 1; s <= N; s++) begin
      if (valid_q[s-1]) begin
        rad_q[s]  <= rad_d[s];
        root_q[s] <= root_d[s];
        rem_q[s]  <= rem_d[s];
      end
    end
  end

  assign y_vld = valid_q[N];
  assign busy  = |valid_q;

`ifdef ISQRT_RESP_ROUND_EN
  // Round to nearest: bump the root when the final remainder exceeds it, saturating at 0xFFFF
  always_comb begin
    y = root_q[N];
    if ((rem_q[N] > {2'b00, root_q[N]}) && (root_q[N] != 16'hFFFF)) begin
      y = root_q[N] + 16'd1;
    end
  end
`else
  assign y = root_q[N];
`endif

endmodule

// File: tb/tb_isqrt_pipe_responder.sv
// Testbench for isqrt_pipe_responder.
// Five DUT copies, one per legal BITS_PER_CYCLE value, share the same stimulus.
// A cycle-indexed history of accepted arguments predicts y_vld, y and busy
// for each copy. Directed scenarios then check copy 0 (BITS_PER_CYCLE=1)
// against fixed constants.

module tb_isqrt_pipe_responder;

  localparam int NUM_DUT = 5;
  localparam int MAXC    = 8192;

  logic        clk;
  logic        rst_n;
  logic        x_vld;
  logic [31:0] x;
  logic        yVld    [NUM_DUT];
  logic [15:0] yArr    [NUM_DUT];
  logic        busyArr [NUM_DUT];

  int checks;
  int failures;
  int cyc;

  bit          accHist [0:MAXC-1];
  logic [31:0] xHist   [0:MAXC-1];

  int          logCyc[$];
  logic [15:0] logY[$];
  int          issueCyc[$];
  logic [31:0] dirX[$];
  logic [15:0] dirY[$];

  // One DUT per BITS_PER_CYCLE value 1,2,4,8,16
  for (genvar k = 0; k < NUM_DUT; k++) begin : g_dut
    isqrt_pipe_responder #(.BITS_PER_CYCLE(1 << k)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .x_vld (x_vld),
      .x     (x),
      .y_vld (yVld[k]),
      .y     (yArr[k]),
      .busy  (busyArr[k])
    );
  end

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it if it mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: floor(sqrt(v)) by binary search, plus optional rounding
  function automatic logic [15:0] refSqrt(input logic [31:0] v);
    longint lo;
    longint hi;
    longint mid;
    longint vv;
    vv = longint'({32'd0, v});
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= vv) lo = mid;
      else hi = mid - 1;
    end
`ifdef ISQRT_RESP_ROUND_EN
    if ((vv - lo * lo) > lo && lo < 65535) lo = lo + 1;
`endif
    return 16'(lo);
  endfunction

  // Drive one cycle of input just after the rising edge
  task automatic applyStimulus(input logic v, input logic [31:0] val);
    @(posedge clk);
    #1;
    x_vld = v;
    x     = val;
  endtask

  // Record accepted arguments at each edge and check every DUT at the falling edge
  initial begin : monitor
    int n;
    int idx;
    bit expV;
    bit expB;
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (cyc < MAXC) begin
        accHist[cyc] = rst_n && x_vld;
        xHist[cyc]   = x;
      end
      @(negedge clk);
      if (rst_n && cyc < MAXC) begin
        for (int k = 0; k < NUM_DUT; k++) begin
          n    = 16 >> k;
          idx  = cyc - n;
          expV = (idx >= 1) ? accHist[idx] : 1'b0;
          expB = 1'b0;
          for (int j = idx; j <= cyc; j++) begin
            if (j >= 1 && accHist[j]) expB = 1'b1;
          end
          checkOutput($sformatf("y_vld[bpc=%0d]", 1 << k), 32'(yVld[k]), 32'(expV));
          checkOutput($sformatf("busy[bpc=%0d]", 1 << k), 32'(busyArr[k]), 32'(expB));
          if (expV) begin
            checkOutput($sformatf("y[bpc=%0d,x=%0h]", 1 << k, xHist[idx]),
                        32'(yArr[k]), 32'(refSqrt(xHist[idx])));
          end
        end
        if (yVld[0]) begin
          logCyc.push_back(cyc);
          logY.push_back(yArr[0]);
        end
      end
    end
  end

  // Issue dirX with 'gap' idle cycles between arguments, then check copy 0 results
  task automatic runDirected(input string name, input int gap);
    logCyc.delete();
    logY.delete();
    issueCyc.delete();
    foreach (dirX[i]) begin
      applyStimulus(1'b1, dirX[i]);
      issueCyc.push_back(cyc + 1);
      for (int g = 0; g < gap; g++) begin
        applyStimulus(1'b0, $urandom);
      end
    end
    for (int g = 0; g < 20; g++) begin
      applyStimulus(1'b0, $urandom);
    end
    checkOutput({name, "_count"}, 32'(logY.size()), 32'(dirX.size()));
    for (int i = 0; i < dirX.size() && i < logY.size(); i++) begin
      checkOutput($sformatf("%s_latency%0d", name, i), 32'(logCyc[i] - issueCyc[i]), 32'd16);
      checkOutput($sformatf("%s_y%0d", name, i), 32'(logY[i]), 32'(dirY[i]));
    end
  endtask

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    failures++;
    $display("[TB] FAIL watchdog expired got=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  // Main sequence
  initial begin
    checks   = 0;
    failures = 0;
    x_vld    = 1'b0;
    x        = '0;
    rst_n    = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NUM_DUT; k++) begin
      checkOutput($sformatf("reset_y_vld%0d", k), 32'(yVld[k]), 32'd0);
      checkOutput($sformatf("reset_busy%0d", k), 32'(busyArr[k]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single argument: x=16 -> 4 after 16 cycles, busy high in between
    dirX = '{32'd16};
    dirY = '{16'd4};
    logCyc.delete();
    logY.delete();
    issueCyc.delete();
    applyStimulus(1'b1, 32'd16);
    issueCyc.push_back(cyc + 1);
    for (int g = 0; g < 8; g++) applyStimulus(1'b0, $urandom);
    @(negedge clk);
    checkOutput("single_busy_mid", 32'(busyArr[0]), 32'd1);
    for (int g = 0; g < 12; g++) applyStimulus(1'b0, $urandom);
    @(negedge clk);
    checkOutput("single_busy_after", 32'(busyArr[0]), 32'd0);
    checkOutput("single_count", 32'(logY.size()), 32'd1);
    if (logY.size() >= 1) begin
      checkOutput("single_latency", 32'(logCyc[0] - issueCyc[0]), 32'd16);
      checkOutput("single_y", 32'(logY[0]), 32'd4);
    end

    // Back-to-back arguments
    dirX = '{32'd100, 32'd144, 32'd169, 32'd0};
    dirY = '{16'd10, 16'd12, 16'd13, 16'd0};
    runDirected("b2b", 0);

    // Idle gaps, including the all-ones boundary
    dirX = '{32'd2, 32'd15, 32'hFFFFFFFF};
    dirY = '{16'd1, 16'd3, 16'hFFFF};
    runDirected("gaps", 1);

    // Rounding behaviour
    dirX = '{32'd12, 32'd13, 32'hFFFFFFFF};
`ifdef ISQRT_RESP_ROUND_EN
    dirY = '{16'd3, 16'd4, 16'hFFFF};
`else
    dirY = '{16'd3, 16'd3, 16'hFFFF};
`endif
    runDirected("round", 0);

    // Reset with five arguments in flight
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom);
    applyStimulus(1'b0, 32'd0);
    applyStimulus(1'b0, 32'd0);
    @(negedge clk);
    checkOutput("inflight_busy", 32'(busyArr[0]), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    for (int j = 0; j <= cyc && j < MAXC; j++) accHist[j] = 1'b0;
    #1;
    for (int k = 0; k < NUM_DUT; k++) begin
      checkOutput($sformatf("midreset_y_vld%0d", k), 32'(yVld[k]), 32'd0);
      checkOutput($sformatf("midreset_busy%0d", k), 32'(busyArr[k]), 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    dirX = '{32'd81};
    dirY = '{16'd9};
    runDirected("after_reset", 0);

    // Randomized traffic on all five copies, checked by the monitor
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] rx;
      case ($urandom_range(0, 9))
        0:       rx = 32'hFFFFFFFF;
        1:       rx = 32'(i % 4);
        2: begin
          rx = 32'($urandom_range(0, 65535));
          rx = rx * rx;
        end
        default: rx = $urandom;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, rx);
    end
    for (int g = 0; g < 20; g++) applyStimulus(1'b0, $urandom);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
